zion_riscv_add_sub_issue: RTL

Decode-side issue stage for the add/sub execution path: accepts a RISC-V instruction with its register operands over a valid/ready handshake, decodes every instruction that uses the adder/subtractor, and drives a registered `op`/`s1`/`s2` bundle plus less-than sideband toward the AddSub executor. It sits between register read and execute. A two-entry elastic buffer gives full throughput with a registered upstream ready.

---
 rtl/zion_riscv_add_sub_issue_pkg.sv | 35 +++
 rtl/zion_riscv_add_sub_decode.sv | 94 +++++++++
 rtl/zion_riscv_add_sub_issue.sv | 111 +++++++++++
 3 files changed

// File: rtl/zion_riscv_add_sub_issue_pkg.sv
// Shared encodings and the issue-bundle type for the add/sub issue stage.
// Bundle fields are sized for RV64; RV32 builds use the low halves.
package zion_riscv_add_sub_issue_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
  localparam logic [6:0] OPC_OP_32     = 7'b0111011;
  localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;

  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;

  localparam logic [6:0] F7_ZERO = 7'b0000000;
  localparam logic [6:0] F7_SUB  = 7'b0100000;

  localparam int unsigned ADD_BIT = 0;
  localparam int unsigned SUB_BIT = 1;
  localparam int unsigned W_BIT   = 2;

  typedef struct packed {
    logic [2:0]  op;
    logic [63:0] s1;
    logic [63:0] s2;
    logic        ltReq;
    logic        unsignedFlg;
    logic        geFlg;
  } issueBundleT;

  function automatic logic [63:0] immSext(input logic [31:0] inst);
    return {{52{inst[31]}}, inst[31:20]};
  endfunction

endpackage

// File: rtl/zion_riscv_add_sub_decode.sv
// Combinational decode of one instruction plus operands into an issue bundle.
// Anything outside the add/sub decode set raises illegal.
module zion_riscv_add_sub_decode
  import zion_riscv_add_sub_issue_pkg::*;
#(
  parameter int unsigned RV64 = 0,
  localparam int unsigned XLEN = 32 * (RV64 + 1)
) (
  input  logic [31:0]     iInst,
  input  logic [XLEN-1:0] iRs1Data,
  input  logic [XLEN-1:0] iRs2Data,
  output issueBundleT     oBundle,
  output logic            oIllegal
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic [6:0]      f7;
  logic            useImm;
  logic [63:0]     imm64;
  logic [XLEN-1:0] immX;
  logic            unusedInst;

  assign opc   = iInst[6:0];
  assign f3    = iInst[14:12];
  assign f7    = iInst[31:25];
  assign imm64 = immSext(iInst);
  assign immX  = imm64[XLEN-1:0];
  assign unusedInst = ^{iInst[19:15], iInst[11:7]};

  always_comb begin
    oBundle  = '0;
    oIllegal = 1'b1;
    useImm   = 1'b0;
    case (opc)
      OPC_OP: begin
        if (f3 == F3_ADD && f7 == F7_ZERO) begin
          oBundle.op[ADD_BIT] = 1'b1;
          oIllegal = 1'b0;
        end else if (f3 == F3_ADD && f7 == F7_SUB) begin
          oBundle.op[SUB_BIT] = 1'b1;
          oIllegal = 1'b0;
        end else if ((f3 == F3_SLT || f3 == F3_SLTU) && f7 == F7_ZERO) begin
          oBundle.op[SUB_BIT]  = 1'b1;
          oBundle.ltReq        = 1'b1;
          oBundle.unsignedFlg  = f3[0];
          oIllegal = 1'b0;
        end
      end
      OPC_OP_IMM: begin
        useImm = 1'b1;
        if (f3 == F3_ADD) begin
          oBundle.op[ADD_BIT] = 1'b1;
          oIllegal = 1'b0;
        end else if (f3 == F3_SLT || f3 == F3_SLTU) begin
          oBundle.op[SUB_BIT] = 1'b1;
          oBundle.ltReq       = 1'b1;
          oBundle.unsignedFlg = f3[0];
          oIllegal = 1'b0;
        end
      end
      OPC_BRANCH: begin
        // f3 = 1 u g : BLT/BGE/BLTU/BGEU
        if (f3[2]) begin
          oBundle.op[SUB_BIT] = 1'b1;
          oBundle.ltReq       = 1'b1;
          oBundle.unsignedFlg = f3[1];
          oBundle.geFlg       = f3[0];
          oIllegal = 1'b0;
        end
      end
      OPC_OP_32: begin
        if (RV64 != 0 && f3 == F3_ADD && (f7 == F7_ZERO || f7 == F7_SUB)) begin
          oBundle.op[W_BIT]   = 1'b1;
          oBundle.op[ADD_BIT] = (f7 == F7_ZERO);
          oBundle.op[SUB_BIT] = (f7 == F7_SUB);
          oIllegal = 1'b0;
        end
      end
      OPC_OP_IMM_32: begin
        useImm = 1'b1;
        if (RV64 != 0 && f3 == F3_ADD) begin
          oBundle.op[W_BIT]   = 1'b1;
          oBundle.op[ADD_BIT] = 1'b1;
          oIllegal = 1'b0;
        end
      end
      default: ;
    endcase
    oBundle.s1 = 64'(iRs1Data);
    oBundle.s2 = useImm ? 64'(immX) : 64'(iRs2Data);
  end

endmodule

// File: rtl/zion_riscv_add_sub_issue.sv
// Add/sub issue stage: decode plus a two-entry (output + skid) elastic buffer.
// Define ZION_RISCV_ADDSUB_ISSUE_ILLEGAL_CNT_EN to add a saturating illegal counter.
module zion_riscv_add_sub_issue
  import zion_riscv_add_sub_issue_pkg::*;
#(
  parameter int unsigned RV64 = 0,
  localparam int unsigned XLEN = 32 * (RV64 + 1),
  localparam int unsigned OPW  = RV64 + 2
) (
  input  logic            iClk,
  input  logic            iRst,
  input  logic            iInstValid,
  output logic            oInstReady,
  input  logic [31:0]     iInst,
  input  logic [XLEN-1:0] iRs1Data,
  input  logic [XLEN-1:0] iRs2Data,
  output logic            oIssueValid,
  input  logic            iIssueReady,
  output logic [OPW-1:0]  oOp,
  output logic [XLEN-1:0] oS1,
  output logic [XLEN-1:0] oS2,
  output logic            oLtReq,
  output logic            oUnsignedFlg,
  output logic            oGeFlg,
  output logic            oIllegal
`ifdef ZION_RISCV_ADDSUB_ISSUE_ILLEGAL_CNT_EN
  ,
  output logic [15:0]     oIllegalCnt
`endif
);

  issueBundleT decBundle;
  logic        decIllegal;
  logic        accept;
  logic        legalAccept;

  issueBundleT outQ;
  issueBundleT skidQ;
  logic        outValidQ;
  logic        skidValidQ;
  logic        readyQ;
  logic        illegalQ;
  logic        unusedOut;

  zion_riscv_add_sub_decode #(
    .RV64(RV64)
  ) uDecode (
    .iInst   (iInst),
    .iRs1Data(iRs1Data),
    .iRs2Data(iRs2Data),
    .oBundle (decBundle),
    .oIllegal(decIllegal)
  );

  assign accept      = iInstValid && readyQ;
  assign legalAccept = accept && !decIllegal;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      outQ       <= '0;
      skidQ      <= '0;
      outValidQ  <= 1'b0;
      skidValidQ <= 1'b0;
      readyQ     <= 1'b1;
      illegalQ   <= 1'b0;
    end else begin
      illegalQ <= accept && decIllegal;
      if (skidValidQ) begin
        // readyQ is low here, so no new beat can arrive this cycle
        if (iIssueReady) begin
          outQ       <= skidQ;
          skidValidQ <= 1'b0;
          readyQ     <= 1'b1;
        end
      end else if (!outValidQ || iIssueReady) begin
        outValidQ <= legalAccept;
        if (legalAccept) outQ <= decBundle;
      end else if (legalAccept) begin
        skidQ      <= decBundle;
        skidValidQ <= 1'b1;
        readyQ     <= 1'b0;
      end
    end
  end

  assign oInstReady   = readyQ;
  assign oIssueValid  = outValidQ;
  assign oOp          = outQ.op[OPW-1:0];
  assign oS1          = outQ.s1[XLEN-1:0];
  assign oS2          = outQ.s2[XLEN-1:0];
  assign oLtReq       = outQ.ltReq;
  assign oUnsignedFlg = outQ.unsignedFlg;
  assign oGeFlg       = outQ.geFlg;
  assign oIllegal     = illegalQ;
  assign unusedOut    = ^outQ;

`ifdef ZION_RISCV_ADDSUB_ISSUE_ILLEGAL_CNT_EN
  logic [15:0] illegalCntQ;

  always_ff @(posedge iClk) begin
    if (iRst) begin
      illegalCntQ <= '0;
    end else if (illegalQ && illegalCntQ != 16'hFFFF) begin
      illegalCntQ <= illegalCntQ + 16'd1;
    end
  end

  assign oIllegalCnt = illegalCntQ;
`endif

endmodule
